uart_word_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_word_rx_if.sv | 19 +
 rtl/uart_byte_rx.sv | 101 ++++++++++
 rtl/uart_word_rx.sv | 105 ++++++++++
 tb/tb_uart_word_rx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word receiver.
// Holds the bit-FSM states and baud-counter sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } bit_state_t;

  function automatic int cycles_per_bit(
    input int clk_freq,
    input int bit_rate
  );
    return clk_freq / bit_rate;
  endfunction

  function automatic int cnt_width(
    input int clk_freq,
    input int bit_rate
  );
    return $clog2(cycles_per_bit(clk_freq, bit_rate));
  endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// Word output handshake of the UART word receiver.
// master drives word_valid_o/word_o, slave drives word_ready_i.
interface uart_word_rx_if;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_o;

  modport master (
    output word_valid_o,
    output word_o,
    input  word_ready_i
  );

  modport slave (
    input  word_valid_o,
    input  word_o,
    output word_ready_i
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rx synchronizer, bit FSM, baud counter.
// Ports: clk, rst_n, rx in; byte_valid, byte_data, frame_error, idle out.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error,
  output logic       idle
);

  localparam int CPB = cycles_per_bit(CLK_FREQ, BIT_RATE);
  localparam int CW  = cnt_width(CLK_FREQ, BIT_RATE);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  logic          s1;
  logic          s2;
  logic          prev;
  bit_state_t    st;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;

  assign idle = (st == IDLE);

  // prev makes IDLE wait for a high-to-low edge, so a line
  // still low after a bad stop bit does not re-trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      prev        <= 1'b1;
      st          <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sr          <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_error <= 1'b0;
    end else begin
      s1          <= rx;
      s2          <= s1;
      prev        <= s2;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (st)
        IDLE: begin
          if (!s2 && prev) begin
            st  <= START;
            cnt <= HALF_M1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (s2) begin
              st <= IDLE;
            end else begin
              st  <= DATA;
              cnt <= FULL_M1;
              idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            sr  <= {s2, sr[7:1]};
            cnt <= FULL_M1;
            idx <= idx + 1'b1;
            if (idx == 3'd7) st <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            st <= IDLE;
            if (s2) begin
              byte_valid <= 1'b1;
              byte_data  <= sr;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs WORD_SIZE_BY bytes MSB first.
// Ports: clk, rst_n, rx, wif (master), error/timeout/overrun pulses.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int WORD_SIZE_BY = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_word_rx_if.master wif,
  output logic           frame_error_o,
  output logic           timeout_o,
  output logic           overrun_o
);

  localparam int CPB   = cycles_per_bit(CLK_FREQ, BIT_RATE);
  localparam int LIMIT = TIMEOUT_BITS * CPB;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_error;
  logic        idle;

  logic [2:0]  cnt;
  logic [23:0] shift;
  logic [31:0] tcnt;
  logic [31:0] word_q;
  logic        vld;
  logic [23:0] base;
  logic [31:0] next_word;
  logic        last;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BIT_RATE(BIT_RATE)
  ) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(frame_error),
    .idle       (idle)
  );

  assign wif.word_valid_o = vld;
  assign wif.word_o       = word_q;
  assign frame_error_o    = frame_error;

  // First byte of a word starts from a clean shift register,
  // which also keeps unused upper bytes at zero.
  assign base      = (cnt == 3'd0) ? 24'd0 : shift;
  assign next_word = {base, byte_data};
  assign last      = (cnt == 3'(WORD_SIZE_BY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shift     <= '0;
      tcnt      <= '0;
      word_q    <= '0;
      vld       <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
      if (vld && wif.word_ready_i) vld <= 1'b0;
      if (byte_valid) begin
        tcnt  <= '0;
        shift <= next_word[23:0];
        if (last) begin
          cnt <= '0;
          if (!vld || wif.word_ready_i) begin
            word_q <= next_word;
            vld    <= 1'b1;
          end else begin
            overrun_o <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (frame_error) begin
        cnt  <= '0;
        tcnt <= '0;
      end else if (!idle || cnt == 3'd0) begin
        tcnt <= '0;
      end else if (TIMEOUT_BITS != 0) begin
        if (tcnt == 32'(LIMIT - 1)) begin
          timeout_o <= 1'b1;
          cnt       <= '0;
          shift     <= '0;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx (10 clk/bit).
// Two instances: 4-byte and 2-byte words.
module tb_uart_word_rx;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic rx2;
  logic fe, to, ov;
  logic fe2, to2, ov2;

  uart_word_rx_if wif ();
  uart_word_rx_if wif2 ();

  uart_word_rx #(
    .CLK_FREQ(1000000),
    .BIT_RATE(100000),
    .WORD_SIZE_BY(4),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .wif          (wif.master),
    .frame_error_o(fe),
    .timeout_o    (to),
    .overrun_o    (ov)
  );

  uart_word_rx #(
    .CLK_FREQ(1000000),
    .BIT_RATE(100000),
    .WORD_SIZE_BY(2),
    .TIMEOUT_BITS(20)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx2),
    .wif          (wif2.master),
    .frame_error_o(fe2),
    .timeout_o    (to2),
    .overrun_o    (ov2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nw = 0, nw2 = 0;
  int nfe = 0, nto = 0, nov = 0;
  int trise = 0, tto = 0;
  logic [31:0] lw = '0, lw2 = '0;
  logic pv = 1'b0, pv2 = 1'b0;
  int errs = 0, checks = 0;
  int stop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wif.word_valid_o && !pv) begin
      nw++;
      lw = wif.word_o;
      trise = cyc;
    end
    pv = wif.word_valid_o;
    if (wif2.word_valid_o && !pv2) begin
      nw2++;
      lw2 = wif2.word_o;
    end
    pv2 = wif2.word_valid_o;
    if (fe) nfe++;
    if (to) begin
      nto++;
      tto = cyc;
    end
    if (ov) nov++;
  end

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx2 = v;
    else rx = v;
  endtask

  task automatic idle_n(input bit sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(
    input bit sel,
    input logic [7:0] b,
    input bit stop
  );
    set_line(sel, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      repeat (10) @(negedge clk);
    end
    stop_cyc = cyc;
    set_line(sel, stop);
    repeat (10) @(negedge clk);
    set_line(sel, 1'b1);
  endtask

  task automatic send_word(
    input bit sel,
    input logic [31:0] w,
    input int n
  );
    for (int i = 0; i < n; i++)
      send_byte(sel, w[8*(n-1-i) +: 8], 1'b1);
  endtask

  int w0, f0, d;

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rx2 = 1'b1;
    wif.word_ready_i = 1'b1;
    wif2.word_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(wif.word_valid_o), 32'd0);
    chk("rst_word", wif.word_o, 32'd0);
    chk("rst_pulses", 32'({fe, to, ov}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    w0 = nw;
    send_word(1'b0, 32'hDEADBEEF, 4);
    d = trise;
    repeat (20) @(negedge clk);
    d = trise - stop_cyc;
    chk("t1_words", 32'(nw - w0), 32'd1);
    chk("t1_word", lw, 32'hDEADBEEF);
    chk("t1_lat_7_10", 32'(d >= 7 && d <= 10), 32'd1);
    chk("t1_errs", 32'(nfe + nto + nov), 32'd0);

    wif.word_ready_i = 1'b0;
    w0 = nw;
    send_word(1'b0, 32'h11223344, 4);
    send_word(1'b0, 32'h55667788, 4);
    repeat (20) @(negedge clk);
    chk("t2_valid", 32'(wif.word_valid_o), 32'd1);
    chk("t2_word", wif.word_o, 32'h11223344);
    chk("t2_ovr", 32'(nov), 32'd1);
    chk("t2_words", 32'(nw - w0), 32'd1);
    wif.word_ready_i = 1'b1;
    @(negedge clk);
    chk("t2_drop", 32'(wif.word_valid_o), 32'd0);

    w0 = nw;
    send_byte(1'b0, 8'hA5, 1'b0);
    idle_n(1'b0, 20);
    send_word(1'b0, 32'h01020304, 4);
    repeat (20) @(negedge clk);
    chk("t3_fe", 32'(nfe), 32'd1);
    chk("t3_word", lw, 32'h01020304);
    chk("t3_words", 32'(nw - w0), 32'd1);

    w0 = nw;
    send_byte(1'b0, 8'hAA, 1'b1);
    send_byte(1'b0, 8'hBB, 1'b1);
    d = stop_cyc;
    idle_n(1'b0, 250);
    chk("t4_to", 32'(nto), 32'd1);
    chk("t4_to_200_215", 32'((tto - d) >= 200 && (tto - d) <= 215), 32'd1);
    chk("t4_nowd", 32'(nw - w0), 32'd0);
    send_word(1'b0, 32'h01020304, 4);
    repeat (20) @(negedge clk);
    chk("t4_word", lw, 32'h01020304);
    chk("t4_words", 32'(nw - w0), 32'd1);
    chk("t4_fe", 32'(nfe), 32'd1);

    w0 = nw;
    f0 = nfe;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_n(1'b0, 30);
    chk("t5_nowd", 32'(nw - w0), 32'd0);
    chk("t5_nofe", 32'(nfe - f0), 32'd0);
    send_word(1'b0, 32'hCAFEF00D, 4);
    repeat (20) @(negedge clk);
    chk("t5_word", lw, 32'hCAFEF00D);

    w0 = nw;
    send_byte(1'b0, 8'h12, 1'b1);
    send_byte(1'b0, 8'h34, 1'b1);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = ((8'h56 >> i) & 8'h01) != 0;
      repeat (10) @(negedge clk);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_valid", 32'(wif.word_valid_o), 32'd0);
    chk("t6_rst_word", wif.word_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_n(1'b0, 20);
    send_word(1'b0, 32'h9ABCDEF0, 4);
    repeat (20) @(negedge clk);
    chk("t6_word", lw, 32'h9ABCDEF0);
    chk("t6_words", 32'(nw - w0), 32'd1);

    send_word(1'b1, 32'h00001234, 2);
    repeat (20) @(negedge clk);
    chk("t7_words", 32'(nw2), 32'd1);
    chk("t7_word", lw2, 32'h00001234);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
